// File: rtl/pong_score_ctrl.sv
// Round and score controller for the pong game: tracks both scores, detects the winner
// and sequences round resets and serves for the game state machine.
module pong_score_ctrl #(
  parameter int unsigned WIN_SCORE   = 7,
  parameter int unsigned SERVE_DELAY = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       frame_tick,
  input  logic       point_1,
  input  logic       point_2,
  output logic [3:0] score_1,
  output logic [3:0] score_2,
  output logic       gameover,
  output logic       round_rst,
  output logic       serve,
  output logic       serve_v_r,
  output logic       winner,
  output logic [2:0] ctrl_state
);

  localparam logic [3:0] WinVal  = 4'(WIN_SCORE);
  localparam logic [7:0] LastCnt = 8'(SERVE_DELAY - 1);

  typedef enum logic [4:0] {
    StIdle      = 5'b00001,
    StPlay      = 5'b00010,
    StScored    = 5'b00100,
    StServeWait = 5'b01000,
    StOver      = 5'b10000
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       p1_q, p2_q;
  logic [3:0] score1_q, score1_d;
  logic [3:0] score2_q, score2_d;
  logic       gameover_q, gameover_d;
  logic       round_rst_q, round_rst_d;
  logic       serve_q, serve_d;
  logic       serve_v_r_q, serve_v_r_d;
  logic       winner_q, winner_d;
  logic       rise1, rise2;

  // Edge registers run in every state so a level left high never counts as a new point.
  assign rise1 = point_1 & ~p1_q;
  assign rise2 = point_2 & ~p2_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    score1_d    = score1_q;
    score2_d    = score2_q;
    gameover_d  = gameover_q;
    round_rst_d = 1'b0;
    serve_d     = 1'b0;
    serve_v_r_d = serve_v_r_q;
    winner_d    = winner_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          score1_d    = 4'd0;
          score2_d    = 4'd0;
          serve_v_r_d = 1'b1;
          cnt_d       = 8'd0;
          state_d     = StServeWait;
        end
      end
      StPlay: begin
        if (rise1 && rise2) begin
          // Simultaneous points are replayed without scoring.
          round_rst_d = 1'b1;
          state_d     = StScored;
        end else if (rise1) begin
          if (score1_q < WinVal) score1_d = score1_q + 4'd1;
          serve_v_r_d = 1'b1;
          round_rst_d = 1'b1;
          state_d     = StScored;
        end else if (rise2) begin
          if (score2_q < WinVal) score2_d = score2_q + 4'd1;
          serve_v_r_d = 1'b0;
          round_rst_d = 1'b1;
          state_d     = StScored;
        end
      end
      StScored: begin
        if (score1_q == WinVal) begin
          winner_d   = 1'b0;
          gameover_d = 1'b1;
          state_d    = StOver;
        end else if (score2_q == WinVal) begin
          winner_d   = 1'b1;
          gameover_d = 1'b1;
          state_d    = StOver;
        end else begin
          cnt_d   = 8'd0;
          state_d = StServeWait;
        end
      end
      StServeWait: begin
        if (frame_tick) begin
          if (cnt_q == LastCnt) begin
            serve_d = 1'b1;
            cnt_d   = 8'd0;
            state_d = StPlay;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      StOver: begin
        if (start) begin
          score1_d    = 4'd0;
          score2_d    = 4'd0;
          gameover_d  = 1'b0;
          serve_v_r_d = 1'b1;
          round_rst_d = 1'b1;
          cnt_d       = 8'd0;
          state_d     = StServeWait;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= 8'd0;
      p1_q        <= 1'b0;
      p2_q        <= 1'b0;
      score1_q    <= 4'd0;
      score2_q    <= 4'd0;
      gameover_q  <= 1'b0;
      round_rst_q <= 1'b0;
      serve_q     <= 1'b0;
      serve_v_r_q <= 1'b1;
      winner_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      p1_q        <= point_1;
      p2_q        <= point_2;
      score1_q    <= score1_d;
      score2_q    <= score2_d;
      gameover_q  <= gameover_d;
      round_rst_q <= round_rst_d;
      serve_q     <= serve_d;
      serve_v_r_q <= serve_v_r_d;
      winner_q    <= winner_d;
    end
  end

  always_comb begin
    ctrl_state = 3'd0;
    unique case (state_q)
      StIdle:      ctrl_state = 3'd0;
      StPlay:      ctrl_state = 3'd1;
      StScored:    ctrl_state = 3'd2;
      StServeWait: ctrl_state = 3'd3;
      StOver:      ctrl_state = 3'd4;
      default:     ctrl_state = 3'd0;
    endcase
  end

  assign score_1   = score1_q;
  assign score_2   = score2_q;
  assign gameover  = gameover_q;
  assign round_rst = round_rst_q;
  assign serve     = serve_q;
  assign serve_v_r = serve_v_r_q;
  assign winner    = winner_q;

endmodule

// File: tb/tb_pong_score_ctrl.sv
// Scoreboard bench for pong_score_ctrl: random rounds feed a match-level model whose
// expected output events are queued and checked by an independent monitor.
module tb_pong_score_ctrl;

  localparam int W  = 7;
  localparam int SD = 3;

  logic       clk = 1'b0;
  logic       rst, start, frame_tick, point_1, point_2;
  logic [3:0] score_1, score_2;
  logic       gameover, round_rst, serve, serve_v_r, winner;
  logic [2:0] ctrl_state;

  pong_score_ctrl #(.WIN_SCORE(W), .SERVE_DELAY(SD)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .frame_tick (frame_tick),
    .point_1    (point_1),
    .point_2    (point_2),
    .score_1    (score_1),
    .score_2    (score_2),
    .gameover   (gameover),
    .round_rst  (round_rst),
    .serve      (serve),
    .serve_v_r  (serve_v_r),
    .winner     (winner),
    .ctrl_state (ctrl_state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kind: 0 = round_rst pulse, 1 = serve pulse, 2 = gameover rising
  typedef struct {
    int kind;
    int cyc;
    int s1;
    int s2;
    int vr;
    int go;
    int win;
    int st;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   m_s1, m_s2, m_vr, m_win;
  logic go_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int kind, input int c, input int go, input int st);
    exp_t e;
    e = '{kind, c, m_s1, m_s2, m_vr, go, m_win, st};
    q.push_back(e);
  endtask

  task automatic handle(input int kind);
    exp_t  e;
    string nm;
    nm = (kind == 0) ? "round_rst" : (kind == 1) ? "serve" : "gameover";
    n_chk++;
    if (q.size() == 0 || q[0].cyc != cyc || q[0].kind != kind) begin
      n_fail++;
      $display("FAIL unexpected_%s: got event at cycle %0d expected none", nm, cyc);
      return;
    end
    e = q.pop_front();
    chk({nm, "_score_1"}, 32'(score_1), e.s1);
    chk({nm, "_score_2"}, 32'(score_2), e.s2);
    chk({nm, "_serve_v_r"}, 32'(serve_v_r), e.vr);
    chk({nm, "_gameover"}, 32'(gameover), e.go);
    chk({nm, "_state"}, 32'(ctrl_state), e.st);
    if (e.go != 0) chk({nm, "_winner"}, 32'(winner), e.win);
  endtask

  // Monitor: every output event must match the head of the expectation queue.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc < cyc) begin
      n_chk++;
      n_fail++;
      $display("FAIL missed_event kind=%0d: got none expected at cycle %0d", q[0].kind, q[0].cyc);
      void'(q.pop_front());
    end
    if (round_rst === 1'b1) handle(0);
    if (gameover === 1'b1 && go_prev !== 1'b1) handle(2);
    if (serve === 1'b1) handle(1);
    go_prev = gameover;
  end

  task automatic serve_ticks();
    for (int t = 1; t <= SD; t++) begin
      int gap;
      gap = $urandom_range(2, 6);
      repeat (gap) begin
        start = ($urandom_range(0, 7) == 0);
        step();
      end
      start = 1'b0;
      if (t == SD) push(1, cyc + 1, 0, 1);
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
    end
    start = ($urandom_range(0, 3) == 0);
    step();
    start = 1'b0;
  endtask

  task automatic start_match(input bit from_over);
    int h;
    start = 1'b1;
    m_s1  = 0;
    m_s2  = 0;
    m_vr  = 1;
    if (from_over) push(0, cyc + 1, 0, 3);
    h = $urandom_range(1, 3);
    repeat (h) step();
    start = 1'b0;
    serve_ticks();
  endtask

  // outcome: 0 = player 1 scores, 1 = player 2 scores, 2 = both at once
  task automatic play_round(input int outcome, input int hold, input bit through,
                            output bit over);
    int k;
    k    = cyc;
    over = 1'b0;
    if (outcome != 1) point_1 = 1'b1;
    if (outcome != 0) point_2 = 1'b1;
    if (outcome == 0) begin
      if (m_s1 < W) m_s1++;
      m_vr = 1;
    end else if (outcome == 1) begin
      if (m_s2 < W) m_s2++;
      m_vr = 0;
    end
    push(0, k + 1, 0, 2);
    if (m_s1 == W) begin
      m_win = 0;
      over  = 1'b1;
    end else if (m_s2 == W) begin
      m_win = 1;
      over  = 1'b1;
    end
    if (over) push(2, k + 2, 1, 4);
    repeat (hold) step();
    if (!through || over) begin
      point_1 = 1'b0;
      point_2 = 1'b0;
    end
    if (!over) begin
      serve_ticks();
      if (through) begin
        repeat (2) step();
        point_1 = 1'b0;
        point_2 = 1'b0;
      end
      repeat ($urandom_range(2, 4)) step();
    end else begin
      repeat (3) step();
    end
  endtask

  function automatic int rand_outcome();
    int r;
    r = $urandom_range(0, 9);
    return (r < 4) ? 0 : (r < 8) ? 1 : 2;
  endfunction

  task automatic random_match_rest(input bit already_over);
    bit over;
    int n;
    over = already_over;
    n    = 0;
    while (!over && n < 100) begin
      play_round(rand_outcome(), $urandom_range(2, 8), ($urandom_range(0, 2) == 0), over);
      n++;
    end
    chk("match_finished", 32'(over), 1);
  endtask

  task automatic over_poke();
    point_2 = 1'b1;
    repeat (2) step();
    point_2 = 1'b0;
    point_1 = 1'b1;
    repeat (2) step();
    point_1 = 1'b0;
    repeat (2) step();
    chk("over_score_1", 32'(score_1), m_s1);
    chk("over_score_2", 32'(score_2), m_s2);
    chk("over_gameover", 32'(gameover), 1);
    chk("over_winner", 32'(winner), m_win);
    chk("over_state", 32'(ctrl_state), 4);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_score_1"}, 32'(score_1), 0);
    chk({tag, "_score_2"}, 32'(score_2), 0);
    chk({tag, "_gameover"}, 32'(gameover), 0);
    chk({tag, "_round_rst"}, 32'(round_rst), 0);
    chk({tag, "_serve"}, 32'(serve), 0);
    chk({tag, "_serve_v_r"}, 32'(serve_v_r), 1);
    chk({tag, "_winner"}, 32'(winner), 0);
    chk({tag, "_state"}, 32'(ctrl_state), 0);
  endtask

  initial begin
    bit over;
    rst        = 1'b1;
    start      = 1'b0;
    frame_tick = 1'b0;
    point_1    = 1'b0;
    point_2    = 1'b0;
    m_s1 = 0; m_s2 = 0; m_vr = 1; m_win = 0;
    repeat (3) step();
    chk_reset_vals("reset");
    rst = 1'b0;
    repeat (2) step();
    chk("idle_state", 32'(ctrl_state), 0);

    // Match 0: held point_1, a replayed point, then random play.
    start_match(1'b0);
    chk("play_state", 32'(ctrl_state), 1);
    play_round(0, 20, 1'b0, over);
    play_round(2, $urandom_range(2, 8), 1'b0, over);
    random_match_rest(over);
    over_poke();

    // Match 1: player 2 takes every point.
    start_match(1'b1);
    over = 1'b0;
    for (int i = 0; i < W && !over; i++) play_round(1, $urandom_range(2, 6), 1'b0, over);
    chk("p2_sweep_over", 32'(over), 1);
    over_poke();

    // Match 2: fully random.
    start_match(1'b1);
    random_match_rest(1'b0);
    over_poke();

    // Reset mid serve wait with the delay counter at 2: the serve must never appear.
    start = 1'b1;
    m_s1 = 0; m_s2 = 0; m_vr = 1;
    push(0, cyc + 1, 0, 3);
    step();
    start = 1'b0;
    for (int t = 0; t < 2; t++) begin
      repeat ($urandom_range(2, 4)) step();
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
    end
    step();
    chk("pre_rst_state", 32'(ctrl_state), 3);
    rst = 1'b1;
    step();
    chk_reset_vals("mid_rst");
    rst = 1'b0;
    for (int t = 0; t < 5; t++) begin
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      step();
    end
    chk("post_rst_state", 32'(ctrl_state), 0);
    chk("post_rst_serve", 32'(serve), 0);

    repeat (5) step();
    chk("queue_drained", 32'(q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
